// File: rtl/pixel_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | pixel_write_buffer: pixel FIFO feeding single-word frame-buffer writes  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pixel_write_buffer #(
   parameter int          DEPTH        = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          FRAME_PIXELS = 307200
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pixel_ready,
   input  logic [18:0]              pixel_number,
   input  logic [31:0]              rgba,
   input  logic                     frame_ready,
   input  logic                     mem_ack,
   output logic                     stall,
   output logic                     mem_write,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic                     frame_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     bad_pixel
);

   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t        state, state_next;
   logic [18:0]   pix_mem  [DEPTH];
   logic [31:0]   rgba_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, load_ptr;
   logic          in_range, push, pop, load, pending, done_fire;

   assign in_range  = ({13'd0, pixel_number} < 32'(FRAME_PIXELS));
   assign push      = pixel_ready && in_range && (count != FULL);
   assign pop       = (state == REQ) && mem_ack;
   assign stall     = (count == FULL);
   assign mem_write = (state == REQ);
   assign done_fire = pending && (state == IDLE) && (count == '0);

   // On an ack with more entries queued, the entry behind the head is loaded
   // so writes stream back to back.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      load_ptr   = rd_ptr;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_next = REQ;
               load       = 1'b1;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (count > CW'(1)) begin
                  load     = 1'b1;
                  load_ptr = rd_ptr + AW'(1);
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pix_mem[wr_ptr]  <= pixel_number;
         rgba_mem[wr_ptr] <= rgba;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         bad_pixel  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (load) begin
            mem_addr  <= BASE_ADDR + {11'd0, pix_mem[load_ptr], 2'b00};
            mem_wdata <= rgba_mem[load_ptr];
         end
         // A frame_ready arriving on the completion edge merges into that frame.
         pending    <= done_fire ? 1'b0 : (pending | frame_ready);
         frame_done <= done_fire;
         if (pixel_ready && in_range && (count == FULL)) overflow <= 1'b1;
         if (pixel_ready && !in_range)                   bad_pixel <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for pixel_write_buffer: two instances (base 0 and base 0x1000_0000)
// share stimulus; a write scoreboard checks every acknowledged write.
module tb_pixel_write_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pixel_ready = 1'b0;
   logic [18:0] pixel_number = '0;
   logic [31:0] rgba = '0;
   logic        frame_ready = 1'b0;
   logic        mem_ack = 1'b0;

   logic        stall, mem_write, frame_done, overflow, bad_pixel;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  count;
   logic        stall_b, mem_write_b, frame_done_b, overflow_b, bad_pixel_b;
   logic [31:0] mem_addr_b, mem_wdata_b;
   logic [3:0]  count_b;

   always #5 clk = ~clk;

   pixel_write_buffer #(.DEPTH(8), .BASE_ADDR(32'h0000_0000), .FRAME_PIXELS(307200)) dut (
      .clk(clk), .reset(reset), .pixel_ready(pixel_ready), .pixel_number(pixel_number),
      .rgba(rgba), .frame_ready(frame_ready), .mem_ack(mem_ack), .stall(stall),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .frame_done(frame_done), .count(count), .overflow(overflow), .bad_pixel(bad_pixel));

   pixel_write_buffer #(.DEPTH(8), .BASE_ADDR(32'h1000_0000), .FRAME_PIXELS(307200)) dut_b (
      .clk(clk), .reset(reset), .pixel_ready(pixel_ready), .pixel_number(pixel_number),
      .rgba(rgba), .frame_ready(frame_ready), .mem_ack(mem_ack), .stall(stall_b),
      .mem_write(mem_write_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .frame_done(frame_done_b), .count(count_b), .overflow(overflow_b), .bad_pixel(bad_pixel_b));

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [18:0] pn;
      logic [31:0] rgba;
      int          ack_wait;
      bit          accept;
      bit          exp_bad;
      logic [31:0] exp_addr;
   } vec_t;

   exp_t sb[$];
   exp_t e;
   vec_t vecs[5];
   vec_t v5;
   int   total = 0;
   int   bad = 0;
   int   writes = 0;
   int   done_pulses = 0;
   int   w0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [18:0] pn, input logic [31:0] d,
                             input bit accept, input logic [31:0] exp_addr);
      pixel_ready  = 1'b1;
      pixel_number = pn;
      rgba         = d;
      if (accept) sb.push_back('{exp_addr, d});
      tick();
      pixel_ready = 1'b0;
   endtask

   task automatic run_single(input vec_t v, input int idx);
      drive_push(v.pn, v.rgba, v.accept, v.exp_addr);
      chk($sformatf("v%0d_count", idx), 32'(count), 32'(v.accept));
      chk($sformatf("v%0d_bad", idx), 32'(bad_pixel), 32'(v.exp_bad));
      chk($sformatf("v%0d_ovf", idx), 32'(overflow), 32'd0);
      if (v.accept) begin
         chk($sformatf("v%0d_wr_early", idx), 32'(mem_write), 32'd0);
         tick();
         for (int k = 0; k <= v.ack_wait; k++) begin
            chk($sformatf("v%0d_wr_c%0d", idx, k), 32'(mem_write), 32'd1);
            chk($sformatf("v%0d_addr_c%0d", idx, k), mem_addr, v.exp_addr);
            chk($sformatf("v%0d_addrb_c%0d", idx, k), mem_addr_b, v.exp_addr + 32'h1000_0000);
            chk($sformatf("v%0d_data_c%0d", idx, k), mem_wdata, v.rgba);
            if (k < v.ack_wait) tick();
         end
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         chk($sformatf("v%0d_wr_end", idx), 32'(mem_write), 32'd0);
         chk($sformatf("v%0d_cnt_end", idx), 32'(count), 32'd0);
      end else begin
         repeat (3) begin
            tick();
            chk($sformatf("v%0d_no_wr", idx), 32'(mem_write), 32'd0);
            chk($sformatf("v%0d_cnt0", idx), 32'(count), 32'd0);
         end
      end
   endtask

   // Scoreboard: an acknowledged write retires the oldest expected entry.
   always @(negedge clk) begin
      if (reset && mem_write && mem_ack) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: unexpected write addr %h data %h", mem_addr, mem_wdata);
         end else begin
            e = sb.pop_front();
            chk("sb_addr", mem_addr, e.addr);
            chk("sb_data", mem_wdata, e.data);
            chk("sb_addr_b", mem_addr_b, e.addr + 32'h1000_0000);
         end
         writes++;
      end
      if (frame_done) done_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{19'd100,    32'hFF00_FF00, 3, 1'b1, 1'b0, 32'h0000_0190};
      vecs[1] = '{19'd307200, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'h0000_0000};
      vecs[2] = '{19'd307199, 32'h1234_5678, 1, 1'b1, 1'b1, 32'h0012_BFFC};
      vecs[3] = '{19'd7,      32'hCAFE_F00D, 0, 1'b1, 1'b1, 32'h0000_001C};
      vecs[4] = '{19'h7FFFF,  32'h0BAD_F00D, 0, 1'b0, 1'b1, 32'h0000_0000};
      v5      = '{19'd5,      32'h0000_0555, 1, 1'b1, 1'b0, 32'h0000_0014};

      // reset state
      #12;
      chk("rst_write", 32'(mem_write), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_bad", 32'(bad_pixel), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_b_outs", {stall_b, mem_write_b, frame_done_b, overflow_b, bad_pixel_b, count_b},
          32'd0);
      chk("rst_b_bus", mem_addr_b | mem_wdata_b, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      tick();

      // single pixels: latency, held request, range filter
      for (int i = 0; i < 5; i++) run_single(vecs[i], i);

      // fill to full, overflow, then streamed drain
      for (int i = 0; i < 9; i++)
         drive_push(19'(i), 32'hA000_0000 + 32'(i), (i < 8), 32'(i * 4));
      chk("full_count", 32'(count), 32'd8);
      chk("full_stall", 32'(stall), 32'd1);
      chk("full_ovf", 32'(overflow), 32'd1);
      chk("full_head", mem_addr, 32'd0);
      w0 = writes;
      mem_ack = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk("drain_wr", 32'(mem_write), 32'd1);
         tick();
      end
      mem_ack = 1'b0;
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_wr_end", 32'(mem_write), 32'd0);
      chk("drain_stall", 32'(stall), 32'd0);
      chk("drain_ovf", 32'(overflow), 32'd1);
      chk("drain_writes", 32'(writes - w0), 32'd8);
      chk("drain_sb", 32'(sb.size()), 32'd0);

      // frame end with queued pixels and a repeated frame_ready
      done_pulses = 0;
      drive_push(19'd10, 32'h0000_0A0A, 1'b1, 32'd40);
      drive_push(19'd11, 32'h0000_0B0B, 1'b1, 32'd44);
      drive_push(19'd12, 32'h0000_0C0C, 1'b1, 32'd48);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      tick();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         chk("fr_wr", 32'(mem_write), 32'd1);
         tick();
         tick();
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
      end
      chk("fr_idle_done", 32'(frame_done), 32'd0);
      chk("fr_idle_wr", 32'(mem_write), 32'd0);
      chk("fr_early", 32'(done_pulses), 32'd0);
      tick();
      chk("fr_done", 32'(frame_done), 32'd1);
      tick();
      chk("fr_done_low", 32'(frame_done), 32'd0);
      repeat (3) tick();
      chk("fr_pulses", 32'(done_pulses), 32'd1);

      // frame_ready with nothing queued
      done_pulses = 0;
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      chk("ef_done_e", 32'(frame_done), 32'd0);
      tick();
      chk("ef_done", 32'(frame_done), 32'd1);
      chk("ef_wr", 32'(mem_write), 32'd0);
      tick();
      chk("ef_done_low", 32'(frame_done), 32'd0);
      repeat (2) tick();
      chk("ef_pulses", 32'(done_pulses), 32'd1);
      chk("ef_count", 32'(count), 32'd0);

      // asynchronous reset in the middle of a request
      for (int i = 1; i <= 4; i++)
         drive_push(19'(i), 32'h5000_0000 + 32'(i), 1'b1, 32'(i * 4));
      tick();
      chk("mid_wr", 32'(mem_write), 32'd1);
      chk("mid_count", 32'(count), 32'd4);
      #2 reset = 1'b0;
      #1;
      chk("ar_wr", 32'(mem_write), 32'd0);
      chk("ar_wr_b", 32'(mem_write_b), 32'd0);
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_ovf", 32'(overflow), 32'd0);
      chk("ar_done", 32'(frame_done), 32'd0);
      chk("ar_bad", 32'(bad_pixel), 32'd0);
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      tick();
      run_single(v5, 5);

      chk("final_sb", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Downstream of the Rasteriser.
- Captures each shaded pixel (pixel_number plus 32-bit RGBA) in a small FIFO and issues single-word frame-buffer writes over a request/acknowledge memory port.
- Tracks end-of-frame: after frame_ready it drains every queued pixel, then pulses frame_done.
- Asserts stall so the Rasteriser can hold off when the FIFO is full.

Parameters:
DEPTH, 8, FIFO entries (power of two, at least 2)
BASE_ADDR, 32'h0000_0000, byte address of pixel 0 in the frame buffer
FRAME_PIXELS, 307200, number of valid pixel indices (640x480)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
pixel_ready  in  1  one-cycle strobe: pixel_number/rgba valid
pixel_number  in  19  linear pixel index
rgba  in  32  pixel colour
frame_ready  in  1  one-cycle strobe: frame complete upstream
mem_ack  in  1  memory write completed (meaningful only while mem_write=1)
stall  out  1  FIFO full (count==DEPTH)
mem_write  out  1  write request
mem_addr  out  32  byte address of write
mem_wdata  out  32  write data
frame_done  out  1  one-cycle pulse: frame fully written
count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: pixel dropped because FIFO full
bad_pixel  out  1  sticky: pixel dropped because pixel_number >= FRAME_PIXELS

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO emptied, FSM to IDLE, frame-pending flag cleared. mem_write drops immediately; any in-flight write is abandoned.
- Push: pixel_ready sampled at rising edge E.
  - If pixel_number >= FRAME_PIXELS: drop the pixel, set bad_pixel.
  - Else if count < DEPTH: write the entry and increment count.
  - Else: drop the pixel, set overflow. A pop in the same cycle does not rescue the push.
- stall = (count == DEPTH), combinational from count.
- Address: mem_addr = BASE_ADDR + {pixel_number, 2'b00}, 32-bit, wraps modulo 2^32. mem_wdata = rgba of the head entry.
- FSM states: IDLE, REQ.
  - IDLE -> REQ on the edge where count > 0. mem_write, mem_addr and mem_wdata are registered from the head entry.
  - REQ: mem_write=1; mem_addr and mem_wdata are held stable until mem_ack=1 is sampled.
  - On a sampled ack: pop the head. If the FIFO is still non-empty (not counting a same-edge push), stay in REQ, load the next entry, and keep mem_write high (back-to-back writes, one per cycle with ack held high). Otherwise go to IDLE with mem_write=0.
- Latency: a pixel pushed into an empty FIFO in IDLE at edge E sees mem_write=1 after edge E+1.
- mem_ack while mem_write=0: ignored.
- Simultaneous push and pop: count is unchanged and both take effect.
- FIFO order: strictly FIFO; pointers wrap modulo DEPTH.
- Frame handling:
  - frame_ready sampled at an edge sets the pending flag.
  - frame_ready while already pending: merged, no extra frame_done.
  - Pixels pushed after frame_ready but before frame_done are drained before frame_done.
  - frame_done is registered high for exactly one cycle, following the edge where pending=1 && state==IDLE && count==0. The same edge clears pending.
- overflow and bad_pixel clear only on reset.

Test Plan:
1. BASE_ADDR=32'h1000_0000. Push pixel 100, rgba 32'hFF00FF00, at edge E; mem_ack high on the 4th cycle of the request.
   -> mem_write=1 after E+1; mem_addr=32'h1000_0190 and mem_wdata=32'hFF00FF00 stable for 4 cycles; then mem_write=0 and count=0.
2. Push 9 consecutive pixels (0..8) with mem_ack=0.
   -> count reaches 8 and stall=1; pixel 8 dropped and overflow=1. Then hold mem_ack=1: writes to addresses 0,4,...,28 on 8 consecutive cycles, in order; count=0; overflow remains 1.
3. Queue 3 pixels, pulse frame_ready, then a second frame_ready, ack each write after 2 cycles.
   -> exactly one frame_done pulse, 2 edges after the third ack's edge (IDLE edge then output); none earlier.
4. Push pixel_number=307200.
   -> no write issued, count stays 0, bad_pixel=1, overflow=0. A following push of 307199 is written normally to address 0x12BFFC.
5. Assert reset low mid-REQ with 4 entries queued.
   -> mem_write, count, overflow and frame_done are 0 immediately (before the next edge). After release, a new pixel 5 is written to address 0x14 with normal 2-edge latency.
6. frame_ready with the FIFO empty and IDLE at edge E.
   -> frame_done=1 for one cycle following edge E+1; no mem_write activity.
